// File: rtl/laser_tx_serializer.sv
// laser_tx_serializer: frames bytes (start=1, data LSB first, optional even
// parity, stop=0) and drives them onto the laser line, one bit per bit_clk
// period. bit_clk is only edge-detected; CLOCK_50 is the single clock.
// Optional parity bit: define LASER_TX_PARITY_EN.
module laser_tx_serializer #(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              en,
  input  logic              bit_clk,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              laser_out,
  output logic              busy,
  output logic              tx_done
);

  localparam int CNT_W  = $clog2(DATA_W) + 1;
  localparam int STOP_W = $clog2(STOP_BITS) + 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  state_t              r_state;
  logic                r_bit_clk_d;
  logic [DATA_W-1:0]   r_shreg;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [STOP_W-1:0]   r_stop_cnt;
  logic                r_in_ready;
  logic                r_laser;
  logic                r_busy;
  logic                r_tx_done;
  logic                w_bit_tick;
  logic                w_accept;

`ifdef LASER_TX_PARITY_EN
  logic                r_parity;

  // Even parity over the byte as it was accepted.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

  // A bit period starts on each rising edge of bit_clk.
  assign w_bit_tick = bit_clk & ~r_bit_clk_d;
  // Acceptance only happens in IDLE while in_ready is already showing high.
  assign w_accept   = (r_state == S_IDLE) & r_in_ready & in_valid & en;

  assign in_ready  = r_in_ready;
  assign laser_out = r_laser;
  assign busy      = r_busy;
  assign tx_done   = r_tx_done;

  // Delay bit_clk by one system clock for rising-edge detection.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_clk_d <= 1'b0;
    end else begin
      r_bit_clk_d <= bit_clk;
    end
  end

  // Frame sequencer: state, shift register, counters and all registered outputs.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= '0;
      r_in_ready <= 1'b0;
      r_laser    <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_done  <= 1'b0;
`ifdef LASER_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else if (!en) begin
      // Abort: drop the frame and hold the line dark until enabled again.
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_laser    <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_done  <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_laser <= 1'b0;
          if (w_accept) begin
            r_shreg    <= in_data;
            r_state    <= S_WAIT;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b0;
`ifdef LASER_TX_PARITY_EN
            r_parity   <= even_parity(in_data);
`endif
          end else begin
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        S_WAIT: begin
          // The first tick seen here opens the start bit.
          if (w_bit_tick) begin
            r_state <= S_START;
            r_laser <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_tick) begin
            r_laser   <= r_shreg[0];
            r_shreg   <= r_shreg >> 1;
            r_bit_cnt <= '0;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_tick) begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            if (r_bit_cnt == LAST_BIT) begin
              r_stop_cnt <= '0;
`ifdef LASER_TX_PARITY_EN
              r_laser    <= r_parity;
              r_state    <= S_PARITY;
`else
              r_laser    <= 1'b0;
              r_state    <= S_STOP;
`endif
            end else begin
              r_laser <= r_shreg[0];
              r_shreg <= r_shreg >> 1;
            end
          end
        end
`ifdef LASER_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_tick) begin
            r_laser    <= 1'b0;
            r_stop_cnt <= '0;
            r_state    <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          r_laser <= 1'b0;
          if (w_bit_tick) begin
            if (r_stop_cnt == LAST_STOP) begin
              // in_ready is re-armed from IDLE on the following cycle.
              r_tx_done  <= 1'b1;
              r_busy     <= 1'b0;
              r_in_ready <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_stop_cnt <= r_stop_cnt + STOP_W'(1);
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_laser    <= 1'b0;
          r_busy     <= 1'b0;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_laser_tx_serializer.sv
// Directed bench for laser_tx_serializer with an 8-cycle bit_clk.
module tb_laser_tx_serializer;

  localparam int PER = 8;
`ifdef LASER_TX_PARITY_EN
  localparam int FLEN = 11;
`else
  localparam int FLEN = 10;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic       en       = 1'b0;
  logic       bit_clk  = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, laser_out, busy, tx_done;

  int checks = 0;
  int errors = 0;
  int phase = 0;
  int done_pulses = 0;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;  // frame[k] = k-th bit on the line
  } vec_t;
  vec_t vecs[6];

  always #10 CLOCK_50 = ~CLOCK_50;

  laser_tx_serializer #(.DATA_W(8), .STOP_BITS(1)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .en       (en),
    .bit_clk  (bit_clk),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .laser_out(laser_out),
    .busy     (busy),
    .tx_done  (tx_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One system clock; inputs change 1 time unit after the edge.
  task automatic cyc();
    @(posedge CLOCK_50);
    #1;
    phase = (phase + 1) % PER;
    bit_clk = (phase < PER/2);
    if (tx_done === 1'b1) done_pulses++;
  endtask

  task automatic accept(input logic [7:0] d, input string name);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 4*PER) begin cyc(); w++; end
    check({name, " ready"}, 32'(in_ready), 32'd1);
    in_data = d;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    check({name, " ready_drop"}, 32'(in_ready), 32'd0);
    check({name, " busy"}, 32'(busy), 32'd1);
  endtask

  // Waits for the start bit, samples mid-bit, checks tx_done timing.
  task automatic observe(input string name, input logic [10:0] exp_frame, output int wait_cyc);
    logic [10:0] got;
    int done_cnt, done_t;
    got = '0;
    done_cnt = 0;
    done_t = -1;
    wait_cyc = 0;
    while (laser_out !== 1'b1 && wait_cyc < 4*PER) begin cyc(); wait_cyc++; end
    check({name, " start_seen"}, 32'(laser_out), 32'd1);
    for (int t = 0; t < PER*FLEN + 2*PER; t++) begin
      if ((t % PER) == PER/2 && (t / PER) < FLEN) got[t / PER] = laser_out;
      if (tx_done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_t = t;
          check({name, " busy_at_done"}, 32'(busy), 32'd0);
          check({name, " ready_at_done"}, 32'(in_ready), 32'd0);
        end
      end
      if (done_t >= 0 && t == done_t + 1) begin
        check({name, " ready_after_done"}, 32'(in_ready), 32'd1);
        break;
      end
      cyc();
    end
    check({name, " frame"}, 32'(got), 32'(exp_frame));
    check({name, " done_count"}, 32'(done_cnt), 32'd1);
    check({name, " frame_len"}, 32'(done_t), 32'(PER*FLEN));
  endtask

  initial begin
    int wc, w, d0;
    logic [10:0] f01, f80, f0f;

    vecs[0].data = 8'hA5;  vecs[1].data = 8'h00;  vecs[2].data = 8'hFF;
    vecs[3].data = 8'h07;  vecs[4].data = 8'h3C;  vecs[5].data = 8'h81;
`ifdef LASER_TX_PARITY_EN
    vecs[0].frame = 11'b00101001011;
    vecs[1].frame = 11'b00000000001;
    vecs[2].frame = 11'b00111111111;
    vecs[3].frame = 11'b01000001111;
    vecs[4].frame = 11'b00001111001;
    vecs[5].frame = 11'b00100000011;
    f01 = 11'b01000000011;
    f80 = 11'b01100000001;
    f0f = 11'b00000011111;
`else
    vecs[0].frame = 11'b0101001011;
    vecs[1].frame = 11'b0000000001;
    vecs[2].frame = 11'b0111111111;
    vecs[3].frame = 11'b0000001111;
    vecs[4].frame = 11'b0001111001;
    vecs[5].frame = 11'b0100000011;
    f01 = 11'b0000000011;
    f80 = 11'b0100000001;
    f0f = 11'b0000011111;
`endif

    // Reset state
    repeat (3) cyc();
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst laser_out", 32'(laser_out), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst tx_done", 32'(tx_done), 32'd0);
    reset_n = 1'b1;
    en = 1'b1;
    cyc();

    // Table-driven single frames
    for (int i = 0; i < 6; i++) begin
      accept(vecs[i].data, $sformatf("vec%0d", i));
      observe($sformatf("vec%0d", i), vecs[i].frame, wc);
    end

    // Back-to-back with in_valid held high
    w = 0;
    while (in_ready !== 1'b1 && w < 4*PER) begin cyc(); w++; end
    d0 = done_pulses;
    in_data = 8'h01;
    in_valid = 1'b1;
    cyc();
    in_data = 8'h80;
    observe("b2b_01", f01, wc);
    cyc();
    in_valid = 1'b0;
    check("b2b second accept ready", 32'(in_ready), 32'd0);
    check("b2b second accept busy", 32'(busy), 32'd1);
    observe("b2b_80", f80, wc);
    check("b2b gap to start", 32'(wc), 32'd6);
    cyc();
    check("b2b done pulses", 32'(done_pulses - d0), 32'd2);

    // Acceptance on the tick cycle: start bit one full period later
    w = 0;
    while (!(in_ready === 1'b1 && phase == 0) && w < 4*PER) begin cyc(); w++; end
    check("coll aligned", 32'(phase), 32'd0);
    in_data = 8'h3C;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    observe("coll", vecs[4].frame, wc);
    check("coll start delay", 32'(wc), 32'd8);

    // en dropped during data bit 3 of 8'hFF
    accept(8'hFF, "abort");
    w = 0;
    while (laser_out !== 1'b1 && w < 4*PER) begin cyc(); w++; end
    repeat (4*PER + 2) cyc();
    check("abort pre laser", 32'(laser_out), 32'd1);
    d0 = done_pulses;
    en = 1'b0;
    cyc();
    check("abort laser_out", 32'(laser_out), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd0);
    repeat (3*PER) cyc();
    check("abort hold in_ready", 32'(in_ready), 32'd0);
    check("abort hold laser", 32'(laser_out), 32'd0);
    check("abort no tx_done", 32'(done_pulses - d0), 32'd0);
    en = 1'b1;
    cyc();
    check("abort ready on en", 32'(in_ready), 32'd1);
    accept(8'h0F, "after_abort");
    observe("after_abort", f0f, wc);

    // Asynchronous reset during the start bit
    accept(8'h55, "arst");
    w = 0;
    while (laser_out !== 1'b1 && w < 4*PER) begin cyc(); w++; end
    check("arst in start", 32'(laser_out), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst laser_out", 32'(laser_out), 32'd0);
    check("arst busy", 32'(busy), 32'd0);
    check("arst in_ready", 32'(in_ready), 32'd0);
    cyc();
    reset_n = 1'b1;
    cyc();
    cyc();
    check("arst ready again", 32'(in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
